// File: rtl/lsu.sv
// rtl/lsu.sv - RV32I load/store unit with single outstanding memory access
//
// Purpose: accepts one load or store from the execute stage, performs the
// lane-aligned word access on a simple req/gnt + rvalid memory port, and
// returns a one-cycle response carrying extended load data or an error.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   req_valid/req_ready         request handshake (ready only when idle)
//   is_store, funct3, addr,     request fields (RV32I width/sign code)
//   wdata
//   resp_valid, rdata, err      one-cycle completion pulse, load result, error
//   mem_req, mem_we, mem_addr,  memory request, held stable until mem_gnt
//   mem_wstrb, mem_wdata
//   mem_gnt                     memory accepts the request this cycle
//   mem_rvalid, mem_rdata       read data return (only sampled in WAIT)
//
// Configuration macro: LSU_MISALIGN_TRAP_EN
//   defined   - misaligned accesses complete immediately with err=1
//   undefined - offending low address bits are cleared, access proceeds

module lsu (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        resp_valid,
    output logic [31:0] rdata,
    output logic        err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        is_store_q, is_store_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;

    // Request classification on the incoming fields
    logic        f3_legal;
    logic        misaligned;
    logic        trap;
    logic [31:0] addr_fix;

    always_comb begin
        if (is_store) begin
            f3_legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
        end else begin
            f3_legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                       (funct3 == 3'b100) || (funct3 == 3'b101);
        end
        // funct3[1:0]==01 covers both H and HU
        misaligned = ((funct3[1:0] == 2'b01) && addr[0]) ||
                     ((funct3 == 3'b010) && (addr[1:0] != 2'b00));
`ifdef LSU_MISALIGN_TRAP_EN
        trap     = !f3_legal || misaligned;
        addr_fix = addr;
`else
        trap     = !f3_legal;
        addr_fix = addr;
        if (misaligned) begin
            if (funct3 == 3'b010) begin
                addr_fix = {addr[31:2], 2'b00};
            end else begin
                addr_fix = {addr[31:1], 1'b0};
            end
        end
`endif
    end

    // Lane steering for the registered request
    logic [3:0]  strb;
    logic [31:0] wdata_lane;

    always_comb begin
        case (funct3_q[1:0])
            2'b00: begin
                strb       = 4'b0001 << addr_q[1:0];
                wdata_lane = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                strb       = addr_q[1] ? 4'b1100 : 4'b0011;
                wdata_lane = {2{wdata_q[15:0]}};
            end
            default: begin
                strb       = 4'b1111;
                wdata_lane = wdata_q;
            end
        endcase
    end

    // Load extraction: funct3[2] selects zero extension
    logic [31:0] rd_shift;
    logic [15:0] rd_half;
    logic [31:0] load_ext;

    always_comb begin
        rd_shift = mem_rdata >> {addr_q[1:0], 3'b000};
        rd_half  = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (funct3_q[1:0])
            2'b00:   load_ext = {{24{!funct3_q[2] && rd_shift[7]}}, rd_shift[7:0]};
            2'b01:   load_ext = {{16{!funct3_q[2] && rd_half[15]}}, rd_half};
            default: load_ext = mem_rdata;
        endcase
    end

    // Next-state and datapath register updates
    always_comb begin
        state_d    = state_q;
        is_store_d = is_store_q;
        funct3_d   = funct3_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        err_d      = err_q;
        rdata_d    = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    is_store_d = is_store;
                    funct3_d   = funct3;
                    addr_d     = addr_fix;
                    wdata_d    = wdata;
                    err_d      = trap;
                    rdata_d    = 32'd0;
                    state_d    = trap ? S_RESP : S_REQ;
                end
            end
            S_REQ: begin
                if (mem_gnt) begin
                    state_d = is_store_q ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_rvalid) begin
                    rdata_d = load_ext;
                    state_d = S_RESP;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            is_store_q <= 1'b0;
            funct3_q   <= 3'd0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            err_q      <= 1'b0;
            rdata_q    <= 32'd0;
        end else begin
            state_q    <= state_d;
            is_store_q <= is_store_d;
            funct3_q   <= funct3_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
        end
    end

    // Memory outputs are zero outside REQ so nothing stale leaks onto the bus
    always_comb begin
        req_ready  = (state_q == S_IDLE);
        resp_valid = (state_q == S_RESP);
        err        = (state_q == S_RESP) && err_q;
        rdata      = rdata_q;
        mem_req    = (state_q == S_REQ);
        mem_we     = mem_req && is_store_q;
        mem_addr   = mem_req ? {addr_q[31:2], 2'b00} : 32'd0;
        mem_wstrb  = mem_req ? strb : 4'd0;
        mem_wdata  = mem_req ? wdata_lane : 32'd0;
    end

endmodule

// File: tb/tb_lsu.sv
// tb/tb_lsu.sv - directed self-checking testbench for lsu

module tb_lsu;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        resp_valid;
    logic [31:0] rdata;
    logic        err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    int total;
    int bad;

    lsu dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .is_store   (is_store),
        .funct3     (funct3),
        .addr       (addr),
        .wdata      (wdata),
        .resp_valid (resp_valid),
        .rdata      (rdata),
        .err        (err),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wstrb  (mem_wstrb),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Results of the last access
    int          a_lat;
    logic [31:0] a_rdata;
    logic        a_err;
    logic        a_saw_req;
    logic [31:0] a_maddr;
    logic [3:0]  a_strb;
    logic [31:0] a_mwdata;
    logic        a_we;
    logic        a_stable;

    // One access with a memory responder: gnt after gnt_dly REQ cycles,
    // rvalid on the first WAIT cycle. Latency counts edges from accept to
    // the edge at which resp_valid is sampled high.
    task automatic do_access(input logic st, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] wd, input int gnt_dly, input logic [31:0] rd);
        int  reqcnt;
        logic gnt_given;
        reqcnt    = 0;
        gnt_given = 1'b0;
        a_lat     = -1;
        a_rdata   = 32'hx;
        a_err     = 1'bx;
        a_saw_req = 1'b0;
        a_maddr   = 32'd0;
        a_strb    = 4'd0;
        a_mwdata  = 32'd0;
        a_we      = 1'b0;
        a_stable  = 1'b1;
        @(negedge clk);
        req_valid = 1'b1;
        is_store  = st;
        funct3    = f3;
        addr      = a;
        wdata     = wd;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        for (int k = 0; k < 40; k++) begin
            mem_gnt    = 1'b0;
            mem_rvalid = 1'b0;
            if (resp_valid) begin
                a_lat   = k + 1;
                a_rdata = rdata;
                a_err   = err;
                break;
            end
            if (mem_req) begin
                if (!a_saw_req) begin
                    a_maddr  = mem_addr;
                    a_strb   = mem_wstrb;
                    a_mwdata = mem_wdata;
                    a_we     = mem_we;
                end else if (mem_addr !== a_maddr || mem_wstrb !== a_strb ||
                             mem_wdata !== a_mwdata || mem_we !== a_we) begin
                    a_stable = 1'b0;
                end
                a_saw_req = 1'b1;
                reqcnt++;
                mem_gnt   = (reqcnt > gnt_dly);
                gnt_given = mem_gnt;
            end else if (gnt_given) begin
                mem_rvalid = 1'b1;
                mem_rdata  = rd;
            end
            @(negedge clk);
        end
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
    endtask

    logic saw_resp;

    initial begin
        total      = 0;
        bad        = 0;
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        is_store   = 1'b0;
        funct3     = 3'd0;
        addr       = 32'd0;
        wdata      = 32'd0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'd0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wstrb", {28'd0, mem_wstrb}, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        rst_n = 1'b1;

        // LW 0x100
        do_access(1'b0, 3'b010, 32'h0000_0100, 32'd0, 0, 32'hDEAD_BEEF);
        chk("lw_lat", a_lat, 32'd3);
        chk("lw_strb", {28'd0, a_strb}, 32'h0000_000F);
        chk("lw_addr", a_maddr, 32'h0000_0100);
        chk("lw_we", {31'd0, a_we}, 32'd0);
        chk("lw_rdata", a_rdata, 32'hDEAD_BEEF);
        chk("lw_err", {31'd0, a_err}, 32'd0);

        // LB / LBU lane 3
        do_access(1'b0, 3'b000, 32'h0000_0203, 32'd0, 0, 32'h80FF_FF7F);
        chk("lb_addr", a_maddr, 32'h0000_0200);
        chk("lb_strb", {28'd0, a_strb}, 32'h0000_0008);
        chk("lb_rdata", a_rdata, 32'hFFFF_FF80);
        do_access(1'b0, 3'b100, 32'h0000_0203, 32'd0, 0, 32'h80FF_FF7F);
        chk("lbu_rdata", a_rdata, 32'h0000_0080);

        // LH upper half, LHU lower half, LB lane 0 positive
        do_access(1'b0, 3'b001, 32'h0000_0202, 32'd0, 1, 32'h80FF_FF7F);
        chk("lh_lat", a_lat, 32'd4);
        chk("lh_rdata", a_rdata, 32'hFFFF_80FF);
        do_access(1'b0, 3'b101, 32'h0000_0200, 32'd0, 0, 32'h80FF_FF7F);
        chk("lhu_rdata", a_rdata, 32'h0000_FF7F);
        chk("lhu_strb", {28'd0, a_strb}, 32'h0000_0003);
        do_access(1'b0, 3'b000, 32'h0000_0200, 32'd0, 0, 32'h80FF_FF7F);
        chk("lb0_rdata", a_rdata, 32'h0000_007F);

        // SH with delayed grant
        do_access(1'b1, 3'b001, 32'h0000_0302, 32'h1234_ABCD, 4, 32'h5555_5555);
        chk("sh_addr", a_maddr, 32'h0000_0300);
        chk("sh_strb", {28'd0, a_strb}, 32'h0000_000C);
        chk("sh_wdata", a_mwdata, 32'hABCD_ABCD);
        chk("sh_we", {31'd0, a_we}, 32'd1);
        chk("sh_stable", {31'd0, a_stable}, 32'd1);
        chk("sh_lat", a_lat, 32'd6);
        chk("sh_err", {31'd0, a_err}, 32'd0);
        chk("sh_rdata", a_rdata, 32'd0);

        // SB lane 1, SW
        do_access(1'b1, 3'b000, 32'h0000_0101, 32'h0000_00EF, 0, 32'd0);
        chk("sb_strb", {28'd0, a_strb}, 32'h0000_0002);
        chk("sb_wdata", a_mwdata, 32'hEFEF_EFEF);
        chk("sb_lat", a_lat, 32'd2);
        do_access(1'b1, 3'b010, 32'h0000_0104, 32'hCAFE_F00D, 0, 32'd0);
        chk("sw_wdata", a_mwdata, 32'hCAFE_F00D);
        chk("sw_strb", {28'd0, a_strb}, 32'h0000_000F);

        // Misaligned LW 0x101
        do_access(1'b0, 3'b010, 32'h0000_0101, 32'd0, 0, 32'h1122_3344);
`ifdef LSU_MISALIGN_TRAP_EN
        chk("mis_lw_noreq", {31'd0, a_saw_req}, 32'd0);
        chk("mis_lw_lat", a_lat, 32'd1);
        chk("mis_lw_err", {31'd0, a_err}, 32'd1);
`else
        chk("mis_lw_addr", a_maddr, 32'h0000_0100);
        chk("mis_lw_err", {31'd0, a_err}, 32'd0);
        chk("mis_lw_rdata", a_rdata, 32'h1122_3344);
        chk("mis_lw_lat", a_lat, 32'd3);
`endif

        // Illegal store funct3=011, illegal load funct3=110
        do_access(1'b1, 3'b011, 32'h0000_0400, 32'hFFFF_FFFF, 0, 32'd0);
        chk("ill_st_noreq", {31'd0, a_saw_req}, 32'd0);
        chk("ill_st_err", {31'd0, a_err}, 32'd1);
        chk("ill_st_lat", a_lat, 32'd1);
        do_access(1'b0, 3'b110, 32'h0000_0400, 32'd0, 0, 32'd0);
        chk("ill_ld_noreq", {31'd0, a_saw_req}, 32'd0);
        chk("ill_ld_err", {31'd0, a_err}, 32'd1);

        // Reset while in WAIT, then stray rvalid
        @(negedge clk);
        req_valid = 1'b1;
        is_store  = 1'b0;
        funct3    = 3'b010;
        addr      = 32'h0000_0500;
        @(negedge clk);
        req_valid = 1'b0;
        chk("rw_req", {31'd0, mem_req}, 32'd1);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        chk("rw_in_wait", {31'd0, req_ready | mem_req | resp_valid}, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("rw_rst_ready", {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        rst_n      = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h9999_9999;
        saw_resp   = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (resp_valid) saw_resp = 1'b1;
        end
        mem_rvalid = 1'b0;
        chk("rw_no_resp", {31'd0, saw_resp}, 32'd0);
        chk("rw_ready", {31'd0, req_ready}, 32'd1);
        chk("rw_rdata", rdata, 32'd0);

        // Back to normal operation after the abandoned access
        do_access(1'b0, 3'b001, 32'h0000_0506, 32'd0, 2, 32'h7FFF_0001);
        chk("post_lh_rdata", a_rdata, 32'h0000_7FFF);
        chk("post_lh_lat", a_lat, 32'd5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
